// File: rtl/complement_arb.sv
`default_nettype none
// =============================================================================
// complement_arb : two-requester round-robin arbiter feeding the shared 4-lane
// sign-magnitude to two's-complement converter. Optional: COMPLEMENT_ARB_STATS_EN
// Revision: 1.0
// =============================================================================
module complement_arb #(
  parameter int LANE_W    = 16,
  parameter int MAX_BURST = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic                req0_last,
  input  logic [3:0]          req0_sign,
  input  logic [4*LANE_W-1:0] req0_num,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic                req1_last,
  input  logic [3:0]          req1_sign,
  input  logic [4*LANE_W-1:0] req1_num,
  output logic                req1_ready,
  output logic [3:0]          cu_sign,
  output logic [4*LANE_W-1:0] cu_num,
  input  logic [4*LANE_W-1:0] cu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*LANE_W-1:0] out_data,
  output logic                out_id,
  output logic                out_last
`ifdef COMPLEMENT_ARB_STATS_EN
  ,
  output logic [15:0]         stat_beats0,
  output logic [15:0]         stat_beats1,
  output logic [15:0]         stat_stall
`endif
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_GRANT0    = 2'd1;
  localparam logic [1:0] c_GRANT1    = 2'd2;
  localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);
  localparam int         c_DW        = 4 * LANE_W;

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            last_winner_q, last_winner_d;
  logic            out_valid_q, out_valid_d;
  logic [c_DW-1:0] out_data_q, out_data_d;
  logic            out_id_q, out_id_d;
  logic            out_last_q, out_last_d;

  logic       w_can_accept;
  logic       w_xfer0;
  logic       w_xfer1;
  logic       w_xfer;
  logic       w_xfer_last;
  logic       w_max_hit;
  logic       w_burst_end;
  logic [7:0] w_cnt_inc;

  // The output register accepts a new beat when empty or draining this cycle.
  assign w_can_accept = !out_valid_q || out_ready;
  assign w_xfer0      = req0_valid && req0_ready;
  assign w_xfer1      = req1_valid && req1_ready;
  assign w_xfer       = w_xfer0 || w_xfer1;
  assign w_xfer_last  = w_xfer0 ? req0_last : req1_last;
  assign w_cnt_inc    = cnt_q + 8'd1;
  assign w_max_hit    = (MAX_BURST != 0) && (w_cnt_inc == c_MAX_BURST);
  assign w_burst_end  = w_xfer && (w_xfer_last || w_max_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (req0_valid && req1_valid) begin
          state_d = last_winner_q ? c_GRANT0 : c_GRANT1;
        end else if (req0_valid) begin
          state_d = c_GRANT0;
        end else if (req1_valid) begin
          state_d = c_GRANT1;
        end
      end
      c_GRANT0: begin
        if (w_burst_end) begin
          state_d = req1_valid ? c_GRANT1 : c_IDLE;
        end
      end
      c_GRANT1: begin
        if (w_burst_end) begin
          state_d = req0_valid ? c_GRANT0 : c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cu_sign    = '0;
    cu_num     = '0;
    case (state_q)
      c_GRANT0: begin
        req0_ready = w_can_accept;
        cu_sign    = req0_sign;
        cu_num     = req0_num;
      end
      c_GRANT1: begin
        req1_ready = w_can_accept;
        cu_sign    = req1_sign;
        cu_num     = req1_num;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_id_d      = out_id_q;
    out_last_d    = out_last_q;
    cnt_d         = cnt_q;
    last_winner_d = last_winner_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = cu_result;
      out_id_d    = w_xfer1;
      out_last_d  = w_xfer_last;
      cnt_d       = w_cnt_inc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Every burst end hands the grant over (or back to IDLE), so the count restarts.
    if (w_burst_end) begin
      cnt_d         = '0;
      last_winner_d = w_xfer1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_id_q      <= 1'b0;
      out_last_q    <= 1'b0;
      cnt_q         <= '0;
      last_winner_q <= 1'b1;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_id_q      <= out_id_d;
      out_last_q    <= out_last_d;
      cnt_q         <= cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

`ifdef COMPLEMENT_ARB_STATS_EN
  logic [15:0] stat_beats0_q, stat_beats0_d;
  logic [15:0] stat_beats1_q, stat_beats1_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_beats0_d = stat_beats0_q;
    stat_beats1_d = stat_beats1_q;
    stat_stall_d  = stat_stall_q;
    if (w_xfer0 && (stat_beats0_q != 16'hFFFF)) begin
      stat_beats0_d = stat_beats0_q + 16'd1;
    end
    if (w_xfer1 && (stat_beats1_q != 16'hFFFF)) begin
      stat_beats1_d = stat_beats1_q + 16'd1;
    end
    if (out_valid_q && !out_ready && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats0_q <= '0;
      stat_beats1_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_beats0_q <= stat_beats0_d;
      stat_beats1_q <= stat_beats1_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_beats0 = stat_beats0_q;
  assign stat_beats1 = stat_beats1_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_complement_arb.sv
`default_nettype none
// =============================================================================
// tb_complement_arb : directed vector bench for complement_arb (MAX_BURST=4),
// with a behavioural converter model closing the cu_num -> cu_result loop.
// Revision: 1.0
// =============================================================================
module tb_complement_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_last, req0_ready;
  logic [3:0]  req0_sign;
  logic [63:0] req0_num;
  logic        req1_valid, req1_last, req1_ready;
  logic [3:0]  req1_sign;
  logic [63:0] req1_num;
  logic [3:0]  cu_sign;
  logic [63:0] cu_num;
  logic [63:0] cu_result;
  logic        out_valid, out_ready, out_id, out_last;
  logic [63:0] out_data;
`ifdef COMPLEMENT_ARB_STATS_EN
  logic [15:0] stat_beats0, stat_beats1, stat_stall;
`endif

  int checks;
  int errors;

  complement_arb #(.LANE_W(16), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_last  (req0_last),
    .req0_sign  (req0_sign),
    .req0_num   (req0_num),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_last  (req1_last),
    .req1_sign  (req1_sign),
    .req1_num   (req1_num),
    .req1_ready (req1_ready),
    .cu_sign    (cu_sign),
    .cu_num     (cu_num),
    .cu_result  (cu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last)
`ifdef COMPLEMENT_ARB_STATS_EN
    ,
    .stat_beats0 (stat_beats0),
    .stat_beats1 (stat_beats1),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter: zero lane stays zero, else msb ^= sign and low bits negate when msb set.
  function automatic logic [63:0] conv(input logic [3:0] s, input logic [63:0] n);
    logic [63:0] r;
    logic [15:0] lane;
    logic        msb;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      lane = n[l*16 +: 16];
      if (lane != 16'h0000) begin
        msb = s[l] ^ lane[15];
        r[l*16 +: 16] = {msb, msb ? (~lane[14:0] + 15'd1) : lane[14:0]};
      end
    end
    return r;
  endfunction

  always_comb cu_result = conv(cu_sign, cu_num);

  typedef struct {
    bit          rst;
    bit          v0, l0;
    bit [3:0]    s0;
    bit [63:0]   n0;
    bit          v1, l1;
    bit [3:0]    s1;
    bit [63:0]   n1;
    bit          ordy;
    bit          r0, r1;
    bit          ov, id, last;
    bit [63:0]   data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit v0, bit l0, bit [3:0] s0, bit [63:0] n0,
                              bit v1, bit l1, bit [3:0] s1, bit [63:0] n1, bit ordy,
                              bit r0, bit r1, bit ov, bit id, bit last, bit [63:0] data);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.l0 = l0; v.s0 = s0; v.n0 = n0;
    v.v1 = v1; v.l1 = l1; v.s1 = s1; v.n1 = n1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.id = id; v.last = last; v.data = data;
    return v;
  endfunction

  function automatic bit [63:0] L(input bit [15:0] t);
    return {t, t, t, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_last = 1'b0; req0_sign = '0; req0_num = '0;
    req1_valid = 1'b0; req1_last = 1'b0; req1_sign = '0; req1_num = '0;
    out_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [63:0] B1 = 64'h0003_0003_0003_0005;
  localparam logic [63:0] Z  = 64'h0;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    do_reset();

    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_id_last", {62'd0, out_id, out_last}, 64'd0);
    chk("reset_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    chk("reset_cu_num", cu_num, 64'd0);

    // Single requester, 3-beat burst with a grant bubble on the first cycle.
    vecs.push_back(mk(1, 1,0,4'b0001,B1,     0,0,0,Z, 1, 0,0, 0,0,0,Z));
    vecs.push_back(mk(0, 1,0,4'b0001,B1,     0,0,0,Z, 1, 1,0, 1,0,0,64'h0003_0003_0003_FFFB));
    vecs.push_back(mk(0, 1,0,0,L(16'h12),    0,0,0,Z, 1, 1,0, 1,0,0,L(16'h12)));
    vecs.push_back(mk(0, 1,1,0,L(16'h13),    0,0,0,Z, 1, 1,0, 1,0,1,L(16'h13)));
    vecs.push_back(mk(0, 0,0,0,Z,            0,0,0,Z, 1, 0,0, 0,0,0,Z));
    // Both requesters, 2-beat bursts: order 0,1,0,1 with no bubbles after the first.
    vecs.push_back(mk(1, 1,0,0,L(16'hA1), 1,0,0,L(16'hB1), 1, 0,0, 0,0,0,Z));
    vecs.push_back(mk(0, 1,0,0,L(16'hA1), 1,0,0,L(16'hB1), 1, 1,0, 1,0,0,L(16'hA1)));
    vecs.push_back(mk(0, 1,1,0,L(16'hA2), 1,0,0,L(16'hB1), 1, 1,0, 1,0,1,L(16'hA2)));
    vecs.push_back(mk(0, 1,0,0,L(16'hA3), 1,0,0,L(16'hB1), 1, 0,1, 1,1,0,L(16'hB1)));
    vecs.push_back(mk(0, 1,0,0,L(16'hA3), 1,1,0,L(16'hB2), 1, 0,1, 1,1,1,L(16'hB2)));
    vecs.push_back(mk(0, 1,0,0,L(16'hA3), 1,0,0,L(16'hB3), 1, 1,0, 1,0,0,L(16'hA3)));
    vecs.push_back(mk(0, 1,1,0,L(16'hA4), 1,0,0,L(16'hB3), 1, 1,0, 1,0,1,L(16'hA4)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hB3), 1, 0,1, 1,1,0,L(16'hB3)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,1,0,L(16'hB4), 1, 0,1, 1,1,1,L(16'hB4)));
    vecs.push_back(mk(0, 0,0,0,Z,         0,0,0,Z,         1, 0,0, 0,0,0,Z));
    // Forced release after 4 beats of req1; req0 served; req1 resumes, last only on beat 10.
    vecs.push_back(mk(1, 0,0,0,Z,         1,0,0,L(16'hC01), 1, 0,0, 0,0,0,Z));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hC01), 1, 0,1, 1,1,0,L(16'hC01)));
    vecs.push_back(mk(0, 1,0,0,L(16'hD1), 1,0,0,L(16'hC02), 1, 0,1, 1,1,0,L(16'hC02)));
    vecs.push_back(mk(0, 1,0,0,L(16'hD1), 1,0,0,L(16'hC03), 1, 0,1, 1,1,0,L(16'hC03)));
    vecs.push_back(mk(0, 1,0,0,L(16'hD1), 1,0,0,L(16'hC04), 1, 0,1, 1,1,0,L(16'hC04)));
    vecs.push_back(mk(0, 1,0,0,L(16'hD1), 1,0,0,L(16'hC05), 1, 1,0, 1,0,0,L(16'hD1)));
    vecs.push_back(mk(0, 1,1,0,L(16'hD2), 1,0,0,L(16'hC05), 1, 1,0, 1,0,1,L(16'hD2)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hC05), 1, 0,1, 1,1,0,L(16'hC05)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hC06), 1, 0,1, 1,1,0,L(16'hC06)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hC07), 1, 0,1, 1,1,0,L(16'hC07)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hC08), 1, 0,1, 1,1,0,L(16'hC08)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hC09), 1, 0,0, 0,0,0,Z));
    vecs.push_back(mk(0, 0,0,0,Z,         1,0,0,L(16'hC09), 1, 0,1, 1,1,0,L(16'hC09)));
    vecs.push_back(mk(0, 0,0,0,Z,         1,1,0,L(16'hC0A), 1, 0,1, 1,1,1,L(16'hC0A)));
    vecs.push_back(mk(0, 0,0,0,Z,         0,0,0,Z,          1, 0,0, 0,0,0,Z));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req0_valid = vecs[i].v0; req0_last = vecs[i].l0;
      req0_sign  = vecs[i].s0; req0_num  = vecs[i].n0;
      req1_valid = vecs[i].v1; req1_last = vecs[i].l1;
      req1_sign  = vecs[i].s1; req1_num  = vecs[i].n1;
      out_ready  = vecs[i].ordy;
      #2;
      chk($sformatf("vec%0d_ready0", i), {63'd0, req0_ready}, {63'd0, vecs[i].r0});
      chk($sformatf("vec%0d_ready1", i), {63'd0, req1_ready}, {63'd0, vecs[i].r1});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ov});
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d_out_id", i), {63'd0, out_id}, {63'd0, vecs[i].id});
        chk($sformatf("vec%0d_out_last", i), {63'd0, out_last}, {63'd0, vecs[i].last});
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].data);
      end
    end

    // Backpressure for 4 cycles mid-burst; the zero lane with sign set stays zero.
    do_reset();
    req0_valid = 1'b1; req0_sign = 4'b0001; req0_num = 64'h0001_0002_0003_0000;
    tick();
    tick();
    chk("stall_beat1_data", out_data, 64'h0001_0002_0003_0000);
    req0_sign = 4'b0000; req0_num = L(16'h22); out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("stall%0d_ready0", k), {63'd0, req0_ready}, 64'd0);
      tick();
      chk($sformatf("stall%0d_valid", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("stall%0d_hold", k), out_data, 64'h0001_0002_0003_0000);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready0", {63'd0, req0_ready}, 64'd1);
    tick();
    chk("stall_beat2_data", out_data, L(16'h22));
    req0_num = L(16'h23); req0_last = 1'b1;
    tick();
    chk("stall_beat3_last", {62'd0, out_valid, out_last}, 64'd3);
    chk("stall_beat3_data", out_data, L(16'h23));
    req0_valid = 1'b0; req0_last = 1'b0;
    tick();
    chk("stall_drained", {63'd0, out_valid}, 64'd0);
`ifdef COMPLEMENT_ARB_STATS_EN
    chk("stat_stall", {48'd0, stat_stall}, 64'd4);
    chk("stat_beats0", {48'd0, stat_beats0}, 64'd3);
    chk("stat_beats1", {48'd0, stat_beats1}, 64'd0);
`endif

    // Asynchronous reset mid-burst, after req0 has become last winner.
    do_reset();
    req0_valid = 1'b1; req0_last = 1'b1; req0_num = L(16'hE1);
    tick();
    tick();
    chk("areset_e1_data", out_data, L(16'hE1));
    req0_valid = 1'b0; req0_last = 1'b0;
    req1_valid = 1'b1; req1_last = 1'b0; req1_num = L(16'hF1);
    tick();
    tick();
    chk("areset_pre_valid_id", {62'd0, out_valid, out_id}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("areset_idle_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    chk("areset_cu_num", cu_num, 64'd0);
    #1 rst_n = 1'b1;
    req0_valid = 1'b1; req0_num = L(16'h0061);
    #1;
    chk("areset_bubble_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    tick();
    chk("areset_tie_grant0", {62'd0, req0_ready, req1_ready}, 64'd2);
    tick();
    chk("areset_tie_out", {62'd0, out_valid, out_id}, 64'd2);
    chk("areset_tie_data", out_data, L(16'h0061));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/complement_arb.md
Name: complement_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 4-lane sign-magnitude → two's-complement converter in the GEMM accumulate path.
- Each requester (e.g. real/imag product streams) sends bursts of 4-lane beats: 4 sign bits plus 4 magnitude lanes.
- The block grants one requester per burst, drives the shared converter and registers its result with a requester ID toward the accumulator.

Parameters:
- LANE_W, 16, width of one lane; instantiated as `SIGWIDTH+4+`LOW_EXPAND.
- MAX_BURST, 64, beats before a forced grant release; 0 = unlimited; max 255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 beat valid.
- req0_last  in  1  final beat of requester 0 burst.
- req0_sign  in  4  per-lane sign, requester 0.
- req0_num  in  4*LANE_W  lane magnitudes, requester 0.
- req0_ready  out  1  requester 0 beat accepted.
- req1_valid, req1_last, req1_sign, req1_num, req1_ready: same as requester 0, for requester 1.
- cu_sign  out  4  to converter sign input.
- cu_num  out  4*LANE_W  to converter input_num.
- cu_result  in  4*LANE_W  from converter complement_num; combinational.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  4*LANE_W  registered converter result.
- out_id  out  1  source requester of out_data.
- out_last  out  1  registered req_last of the beat.

Behaviour:
- FSM states: IDLE, GRANT0, GRANT1. Reset state is IDLE.
- Reset values: out_valid, out_data, out_id, out_last = 0; the beat counter = 0; last_winner = 1, so requester 0 wins the first tie.
- IDLE transitions:
  - Only req0_valid → GRANT0.
  - Only req1_valid → GRANT1.
  - Both valid → grant goes to !last_winner.
  - Neither valid → stay in IDLE.
  - No beat is accepted in IDLE, so the first burst has a 1-cycle grant bubble.
- reqN_ready = (state==GRANTn) && (!out_valid || out_ready). Only the granted requester can be ready. A beat transfers on reqN_valid && reqN_ready.
- cu_sign/cu_num mux the granted requester's inputs. They are all-zero in IDLE.
- On transfer, cu_result is captured into out_data, along with out_id=n and out_last=reqN_last. out_valid is set to 1. Latency is 1 cycle from transfer to out_valid.
- out_valid clears on out_ready when no new transfer happens in the same cycle. A simultaneous drain and new transfer keeps out_valid=1 and loads the new data; this gives full throughput of 1 beat per cycle.
- While out_valid && !out_ready, out_data, out_id and out_last hold stable.
- Beat counter:
  - Increments on each transfer.
  - Clears on grant change.
  - Burst end = transfer with reqN_last, or counter reaching MAX_BURST (when MAX_BURST≠0).
- At burst end:
  - last_winner is set to n.
  - If the other requester is valid in the same cycle, go directly to GRANT(other) with no bubble.
  - Otherwise go to IDLE.
- A forced release (MAX_BURST) does not alter out_last. The remainder of that burst re-arbitrates as a new burst.
- reqN_valid dropping mid-burst holds the grant; there is no timeout.
- Asserting rst_n low mid-burst immediately returns to IDLE and drops the pending out beat.
- Converter arithmetic belongs to the converter, not this block. Per lane:
  - An all-zero lane stays 0.
  - Otherwise msb = sign^msb, and the low LANE_W-1 bits are negated+1 when the new msb is 1.

Optional Feature:
- COMPLEMENT_ARB_STATS_EN: when defined, adds three output ports, each 16 bits, saturating at 16'hFFFF and reset to 0:
  - stat_beats0: counts requester 0 transfers.
  - stat_beats1: counts requester 1 transfers.
  - stat_stall: counts cycles with out_valid && !out_ready.
- When undefined, these ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset, then req0 only, 3 beats, last on beat 3, out_ready=1. Beat 1: sign=4'b0001, lane0=16'h0005, lanes1-3=16'h0003 → IDLE→GRANT0 bubble; out_data lane0=16'hFFFB, lanes1-3=16'h0003, out_id=0; out_last on beat 3; then IDLE.
- Both valid from reset, 2-beat bursts each, continuously → order 0,1,0,1. No bubble between bursts after the first. out_id alternates per burst.
- out_ready held low 4 cycles mid-burst → reqN_ready=0 and out_data stable for those cycles. With the stats feature compiled in, stat_stall=4. Zero lane 16'h0000 with sign=1 → output 16'h0000.
- MAX_BURST=4, req1 streams 10 beats with last only on beat 10, req0 valid → req1 released after beat 4. req0 burst served next. req1 resumes; out_last=1 only on beat 10.
- rst_n pulsed low asynchronously (between clock edges) mid-burst with out_valid=1 → out_valid=0 immediately; FSM in IDLE; next tie grants req0.
